sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares one single-port SRAM between the instruction-fetch requester (inst) and the load/store requester (data) for a unified-memory build of the 5-stage core.
- Sits between the pipeline stages and the top-level SRAM port.
- Fixed priority: data wins by default. A starvation counter guarantees inst progress.
- Routes 1-cycle-latency read data back to the requester that issued the read.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles inst may be denied before it gains priority for its next grant. Legal range 1..15.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- inst_req  in  1  inst request valid; held until granted
- inst_we  in  4  byte write enables; 0 means read
- inst_addr  in  ADDR_W  byte address
- inst_wdata  in  32  write data
- inst_gnt  out  1  request accepted this cycle
- inst_rvalid  out  1  read data valid; 1-cycle pulse
- inst_rdata  out  32  read data
- data_req / data_we / data_addr / data_wdata / data_gnt / data_rvalid / data_rdata: same as the inst group, for data
- sram_en  out  1  SRAM enable
- sram_we  out  4  SRAM byte write enables
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid one cycle after sram_en with sram_we==0

Behaviour:
- Reset: all state and registered outputs clear asynchronously.
  - rsp_owner = NONE, rsp_pending = 0, starve_cnt = 0.
  - While reset is high: inst_gnt = data_gnt = 0, sram_en = 0, inst_rvalid = data_rvalid = 0.
- Grant is combinational in the cycle of the request:
  - boost = (starve_cnt >= STARVE_LIMIT).
  - Only one requester active: grant it.
  - Both active: grant inst if boost, else grant data.
  - Granted requester's we/addr/wdata drive the SRAM in the same cycle; sram_en = inst_gnt | data_gnt.
  - At most one gnt is high per cycle.
- SRAM mux with no grant: sram_we = 0, sram_addr = 0, sram_wdata = 0.
- Response tracking, registered on posedge clk:
  - rsp_pending <= granted & (granted we == 0).
  - rsp_owner <= the granted requester.
  - A write clears rsp_pending; writes have no response, they complete at grant.
- Response outputs:
  - x_rvalid = rsp_pending & (rsp_owner == x).
  - x_rdata = sram_rdata when x_rvalid, else 0.
  - Read latency from gnt to rvalid: exactly 1 cycle.
- Back-to-back operation:
  - A new grant may issue in the same cycle a response returns; full throughput is one access per cycle.
  - Responses are never queued: one outstanding read at most, always returned the next cycle.
- Starvation counter, 4 bits, saturating at 15:
  - Increments when inst_req & ~inst_gnt.
  - Clears on inst_gnt, or when inst_req = 0.
- Requester contract: req, we, addr and wdata are stable while req is high and gnt is low. The arbiter does not check this.
- Reset mid-read: the pending response is dropped and no rvalid is produced after reset releases.

Optional Feature:
- Macro: SRAM_ARB_PERF_EN.
- With the macro defined, two 32-bit wrap-around counters are added, cleared by reset:
  - perf_conflicts increments each cycle both requesters are active.
  - perf_boosts increments each cycle inst is granted because of boost while data_req is high.
  - Both counters are exposed on output ports perf_conflicts [31:0] and perf_boosts [31:0].
- Without the macro: those ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared constants header entries:
  - Owner encoding: OWNER_NONE = 2'd0, OWNER_INST = 2'd1, OWNER_DATA = 2'd2.
  - Macro-width request bundle {we, addr, wdata} = 68 bits, for concatenation.
- Sub-module arb_starve_cnt: saturating counter plus boost compare, parameterised by STARVE_LIMIT, reusable for later multi-requester arbiters.
- Grant logic and the response mux stay in the top module.

Test Plan:
- Inst-only read:
  - Stimulus: inst_req = 1, inst_we = 0, addr 0x1c000000; SRAM returns 0x02800413.
  - Response: inst_gnt = 1 and sram_en = 1 in cycle 0; inst_rvalid = 1 with rdata 0x02800413 in cycle 1; data_rvalid = 0.
- Conflict:
  - Stimulus: data read 0x100 and inst read 0x1c000004 in the same cycle.
  - Response: data_gnt = 1, inst_gnt = 0; sram_addr = 0x100; data_rvalid next cycle; inst granted in the following cycle.
- Starvation, STARVE_LIMIT = 4:
  - Stimulus: data_req held high continuously with inst_req high.
  - Response: inst denied 4 cycles, granted in cycle 4; starve_cnt returns to 0; data granted again in cycle 5.
- Write then read:
  - Stimulus: data_we = 4'hF, wdata 0xDEADBEEF to 0x200, then a data read of 0x200.
  - Response: no rvalid after the write; the read returns the SRAM value with 1-cycle latency.
- Reset mid-read:
  - Stimulus: assert reset the cycle after an inst read grant.
  - Response: inst_rvalid = 0 immediately and stays 0; all gnt = 0 while reset is high.
- Perf, with SRAM_ARB_PERF_EN defined:
  - Stimulus: 6 conflict cycles with STARVE_LIMIT = 4.
  - Response: perf_conflicts = 6, perf_boosts = 1.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the unified-memory SRAM arbiter.
// Optional performance counters are enabled in the top with SRAM_ARB_PERF_EN.
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_INST = 2'd1,
        OWNER_DATA = 2'd2
    } owner_e;

    localparam int STARVE_CNT_W = 4;
    localparam int STARVE_CNT_MAX = 15;

    // Width of a {we, addr, wdata} request bundle; 68 for a 32-bit address
    localparam int REQ_BUNDLE_W = 68;

    function automatic int reqBundleW(input int addrW);
        return 4 + addrW + 32;
    endfunction

endpackage

// File: rtl/sram_arbiter_starve.sv
// Saturating starvation counter with priority-boost compare, reusable by
// arbiters that need to guarantee a low-priority requester eventually wins.
module arb_starve_cnt
    import sram_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req_i,
    input  logic gnt_i,
    output logic boost_o
);

    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;

    // Counts consecutive denied cycles; any grant or idle cycle restarts it
    always_comb begin
        cnt_d = '0;
        if (req_i && !gnt_i) begin
            if (cnt_q == STARVE_CNT_W'(STARVE_CNT_MAX)) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign boost_o = (cnt_q >= STARVE_CNT_W'(STARVE_LIMIT));

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM between instruction fetch and load/store.
// Define SRAM_ARB_PERF_EN to add conflict/boost performance counters.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic [3:0]        inst_we,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [31:0]       inst_wdata,
    output logic              inst_gnt,
    output logic              inst_rvalid,
    output logic [31:0]       inst_rdata,
    input  logic              data_req,
    input  logic [3:0]        data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_gnt,
    output logic              data_rvalid,
    output logic [31:0]       data_rdata,
    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
`ifdef SRAM_ARB_PERF_EN
    output logic [31:0]       perf_conflicts,
    output logic [31:0]       perf_boosts,
`endif
    input  logic [31:0]       sram_rdata
);

    localparam int REQ_W = reqBundleW(ADDR_W);

    logic             boost;
    logic             instGnt;
    logic             dataGnt;
    logic [REQ_W-1:0] reqBundle;
    owner_e           rspOwner_q;
    owner_e           rspOwner_d;
    logic             rspPending_q;
    logic             rspPending_d;

    arb_starve_cnt #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk    (clk),
        .reset  (reset),
        .req_i  (inst_req),
        .gnt_i  (instGnt),
        .boost_o(boost)
    );

    // Data wins conflicts unless inst has been starved long enough
    always_comb begin
        instGnt = 1'b0;
        dataGnt = 1'b0;
        if (!reset) begin
            if (inst_req && (!data_req || boost)) begin
                instGnt = 1'b1;
            end else if (data_req) begin
                dataGnt = 1'b1;
            end
        end
    end

    always_comb begin
        reqBundle = '0;
        if (instGnt) begin
            reqBundle = {inst_we, inst_addr, inst_wdata};
        end else if (dataGnt) begin
            reqBundle = {data_we, data_addr, data_wdata};
        end
    end

    assign {sram_we, sram_addr, sram_wdata} = reqBundle;
    assign sram_en  = instGnt | dataGnt;
    assign inst_gnt = instGnt;
    assign data_gnt = dataGnt;

    // Only reads leave a response outstanding; writes finish at grant
    always_comb begin
        rspOwner_d = OWNER_NONE;
        if (instGnt) begin
            rspOwner_d = OWNER_INST;
        end else if (dataGnt) begin
            rspOwner_d = OWNER_DATA;
        end
        rspPending_d = sram_en && (sram_we == 4'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rspOwner_q   <= OWNER_NONE;
            rspPending_q <= 1'b0;
        end else begin
            rspOwner_q   <= rspOwner_d;
            rspPending_q <= rspPending_d;
        end
    end

    assign inst_rvalid = rspPending_q && (rspOwner_q == OWNER_INST);
    assign data_rvalid = rspPending_q && (rspOwner_q == OWNER_DATA);
    assign inst_rdata  = inst_rvalid ? sram_rdata : 32'd0;
    assign data_rdata  = data_rvalid ? sram_rdata : 32'd0;

`ifdef SRAM_ARB_PERF_EN
    logic [31:0] perfConflicts_q;
    logic [31:0] perfBoosts_q;

    // Inst can only beat an active data request through the boost path
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perfConflicts_q <= '0;
            perfBoosts_q    <= '0;
        end else begin
            if (inst_req && data_req) begin
                perfConflicts_q <= perfConflicts_q + 32'd1;
            end
            if (instGnt && data_req) begin
                perfBoosts_q <= perfBoosts_q + 32'd1;
            end
        end
    end

    assign perf_conflicts = perfConflicts_q;
    assign perf_boosts    = perfBoosts_q;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter with a behavioural SRAM.
// Perf counter checks are compiled in when SRAM_ARB_PERF_EN is defined.
module tb_sram_arbiter;

    logic        clk;
    logic        reset;
    logic        inst_req;
    logic [3:0]  inst_we;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_gnt;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [3:0]  data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
`ifdef SRAM_ARB_PERF_EN
    logic [31:0] perf_conflicts;
    logic [31:0] perf_boosts;
`endif

    int nAsserts = 0;
    int nFails   = 0;

    logic [31:0] mem [logic [31:0]];

    sram_arbiter #(
        .STARVE_LIMIT(4),
        .ADDR_W      (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .inst_req      (inst_req),
        .inst_we       (inst_we),
        .inst_addr     (inst_addr),
        .inst_wdata    (inst_wdata),
        .inst_gnt      (inst_gnt),
        .inst_rvalid   (inst_rvalid),
        .inst_rdata    (inst_rdata),
        .data_req      (data_req),
        .data_we       (data_we),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_gnt      (data_gnt),
        .data_rvalid   (data_rvalid),
        .data_rdata    (data_rdata),
        .sram_en       (sram_en),
        .sram_we       (sram_we),
        .sram_addr     (sram_addr),
        .sram_wdata    (sram_wdata),
`ifdef SRAM_ARB_PERF_EN
        .perf_conflicts(perf_conflicts),
        .perf_boosts   (perf_boosts),
`endif
        .sram_rdata    (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port SRAM: byte-masked writes, reads return one cycle later
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we != 4'd0) begin
                logic [31:0] word;
                word = mem.exists(sram_addr) ? mem[sram_addr] : 32'd0;
                for (int b = 0; b < 4; b++) begin
                    if (sram_we[b]) word[8*b +: 8] = sram_wdata[8*b +: 8];
                end
                mem[sram_addr] = word;
            end else begin
                sram_rdata <= mem.exists(sram_addr) ? mem[sram_addr] : 32'd0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(
        input logic iReq, input logic [3:0] iWe, input logic [31:0] iAddr, input logic [31:0] iWdata,
        input logic dReq, input logic [3:0] dWe, input logic [31:0] dAddr, input logic [31:0] dWdata);
        inst_req   = iReq;
        inst_we    = iWe;
        inst_addr  = iAddr;
        inst_wdata = iWdata;
        data_req   = dReq;
        data_we    = dWe;
        data_addr  = dAddr;
        data_wdata = dWdata;
        #1;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        sram_rdata = 32'd0;
        mem[32'h1c000000] = 32'h02800413;
        mem[32'h1c000004] = 32'h00000513;
        mem[32'h00000100] = 32'h12345678;

        // Reset: requests present but nothing may be granted
        reset = 1'b1;
        applyStimulus(1'b1, 4'd0, 32'h1c000000, 32'd0, 1'b1, 4'd0, 32'h100, 32'd0);
        checkOutput("rst_inst_gnt", 32'(inst_gnt), 32'd0);
        checkOutput("rst_data_gnt", 32'(data_gnt), 32'd0);
        checkOutput("rst_sram_en", 32'(sram_en), 32'd0);
        stepCycle();
        checkOutput("rst_inst_rvalid", 32'(inst_rvalid), 32'd0);
        checkOutput("rst_data_rvalid", 32'(data_rvalid), 32'd0);
        reset = 1'b0;
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        checkOutput("idle_sram_en", 32'(sram_en), 32'd0);
        checkOutput("idle_sram_addr", sram_addr, 32'd0);
        stepCycle();

        $display("[TB] inst-only read");
        applyStimulus(1'b1, 4'd0, 32'h1c000000, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        checkOutput("t1_inst_gnt", 32'(inst_gnt), 32'd1);
        checkOutput("t1_sram_en", 32'(sram_en), 32'd1);
        checkOutput("t1_sram_addr", sram_addr, 32'h1c000000);
        checkOutput("t1_sram_we", 32'(sram_we), 32'd0);
        stepCycle();
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        checkOutput("t1_inst_rvalid", 32'(inst_rvalid), 32'd1);
        checkOutput("t1_inst_rdata", inst_rdata, 32'h02800413);
        checkOutput("t1_data_rvalid", 32'(data_rvalid), 32'd0);
        checkOutput("t1_data_rdata", data_rdata, 32'd0);
        stepCycle();
        checkOutput("t1_inst_rvalid_pulse", 32'(inst_rvalid), 32'd0);

        $display("[TB] conflict");
        applyStimulus(1'b1, 4'd0, 32'h1c000004, 32'd0, 1'b1, 4'd0, 32'h100, 32'd0);
        checkOutput("t2_data_gnt", 32'(data_gnt), 32'd1);
        checkOutput("t2_inst_gnt", 32'(inst_gnt), 32'd0);
        checkOutput("t2_sram_addr", sram_addr, 32'h100);
        stepCycle();
        applyStimulus(1'b1, 4'd0, 32'h1c000004, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        checkOutput("t2_data_rvalid", 32'(data_rvalid), 32'd1);
        checkOutput("t2_data_rdata", data_rdata, 32'h12345678);
        checkOutput("t2_inst_rvalid", 32'(inst_rvalid), 32'd0);
        checkOutput("t2_inst_gnt_next", 32'(inst_gnt), 32'd1);
        checkOutput("t2_sram_addr_next", sram_addr, 32'h1c000004);
        stepCycle();
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        checkOutput("t2_inst_rvalid_late", 32'(inst_rvalid), 32'd1);
        checkOutput("t2_inst_rdata", inst_rdata, 32'h00000513);
        checkOutput("t2_data_rvalid_late", 32'(data_rvalid), 32'd0);

        // Fresh reset so the perf counters start from zero
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        stepCycle();

        $display("[TB] starvation");
        applyStimulus(1'b1, 4'd0, 32'h1c000000, 32'd0, 1'b1, 4'd0, 32'h100, 32'd0);
        for (int c = 0; c < 6; c++) begin
            checkOutput($sformatf("t3_inst_gnt_c%0d", c), 32'(inst_gnt), (c == 4) ? 32'd1 : 32'd0);
            checkOutput($sformatf("t3_data_gnt_c%0d", c), 32'(data_gnt), (c == 4) ? 32'd0 : 32'd1);
            if (c > 0) begin
                checkOutput($sformatf("t3_inst_rvalid_c%0d", c), 32'(inst_rvalid), (c == 5) ? 32'd1 : 32'd0);
                checkOutput($sformatf("t3_data_rvalid_c%0d", c), 32'(data_rvalid), (c == 5) ? 32'd0 : 32'd1);
            end
            stepCycle();
        end
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        checkOutput("t3_data_rvalid_end", 32'(data_rvalid), 32'd1);
        checkOutput("t3_data_rdata_end", data_rdata, 32'h12345678);
`ifdef SRAM_ARB_PERF_EN
        checkOutput("perf_conflicts", perf_conflicts, 32'd6);
        checkOutput("perf_boosts", perf_boosts, 32'd1);
`endif
        stepCycle();

        $display("[TB] write then read");
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'hF, 32'h200, 32'hDEADBEEF);
        checkOutput("t4_wr_gnt", 32'(data_gnt), 32'd1);
        checkOutput("t4_sram_we", 32'(sram_we), 32'hF);
        checkOutput("t4_sram_wdata", sram_wdata, 32'hDEADBEEF);
        stepCycle();
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd0, 32'h200, 32'd0);
        checkOutput("t4_no_rvalid_after_write", 32'(data_rvalid), 32'd0);
        checkOutput("t4_rd_gnt", 32'(data_gnt), 32'd1);
        checkOutput("t4_rd_sram_wdata", sram_wdata, 32'd0);
        stepCycle();
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        checkOutput("t4_rd_rvalid", 32'(data_rvalid), 32'd1);
        checkOutput("t4_rd_rdata", data_rdata, 32'hDEADBEEF);
        stepCycle();

        $display("[TB] reset mid-read");
        applyStimulus(1'b1, 4'd0, 32'h1c000000, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        checkOutput("t5_inst_gnt", 32'(inst_gnt), 32'd1);
        stepCycle();
        reset = 1'b1;
        applyStimulus(1'b1, 4'd0, 32'h1c000004, 32'd0, 1'b1, 4'd0, 32'h100, 32'd0);
        checkOutput("t5_rvalid_dropped", 32'(inst_rvalid), 32'd0);
        checkOutput("t5_rdata_dropped", inst_rdata, 32'd0);
        checkOutput("t5_rst_inst_gnt", 32'(inst_gnt), 32'd0);
        checkOutput("t5_rst_data_gnt", 32'(data_gnt), 32'd0);
        checkOutput("t5_rst_sram_en", 32'(sram_en), 32'd0);
        stepCycle();
        reset = 1'b0;
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        checkOutput("t5_rvalid_after_release", 32'(inst_rvalid), 32'd0);
        stepCycle();
        checkOutput("t5_rvalid_stays_low", 32'(inst_rvalid), 32'd0);
        checkOutput("t5_data_rvalid_low", 32'(data_rvalid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
